mem_stage_ctrl: RTL and testbench
=================================

Name: mem_stage_ctrl

Overview:
- Memory-stage controller on the consuming side of the X/M pipeline latch.
- Takes the registered ALU result, store data, destination register and lw/sw/exception flags from X/M, and runs a req/ack transaction with data memory.
- Stalls the upstream pipeline until the transaction completes, then presents a registered result to the M/W stage.
- Non-memory instructions pass through in one cycle.

Parameters:
ADDR_W, 12, data-memory word-address width; dmem_addr = exec_out_xm[ADDR_W-1:0]
TIMEOUT, 15, ACCESS cycles without dmem_ack before a bus-timeout exception
EXC_ADDR, 7, rstatus code written on an out-of-range address
EXC_TIMEOUT, 6, rstatus code written on a timeout

Ports:
clock  in  1  system clock, rising edge
clrn  in  1  asynchronous active-low reset
exec_out_xm  in  32  ALU result / effective address
rd_out1_xm  in  32  store data
rd_xm  in  5  destination register
regwrite_xm  in  1  instruction writes rd
isLw_xm  in  1  load
isSw_xm  in  1  store
exception_xm  in  1  exception already raised upstream
dmem_req  out  1  memory request, held until ack or timeout
dmem_we  out  1  1 = write
dmem_addr  out  ADDR_W  word address
dmem_wdata  out  32  write data
dmem_ack  in  1  one-cycle completion strobe
dmem_rdata  in  32  read data, valid with dmem_ack
stall_m  out  1  freeze X/M latch and all earlier stages
data_mw  out  32  result to M/W
rd_mw  out  5  destination to M/W
wren_mw  out  1  register-file write enable to M/W
exception_mw  out  1  exception flag to M/W

Behaviour:
- Reset (clrn low, asynchronous): state = IDLE; counter = 0; all registered outputs = 0 (dmem_req, dmem_we, dmem_addr, dmem_wdata, data_mw, rd_mw, wren_mw, exception_mw). Reset mid-ACCESS drops dmem_req immediately; the transaction is abandoned with no M/W write.
- memop = (isLw_xm | isSw_xm) & ~exception_xm.
- oor = exec_out_xm[31:ADDR_W] != 0.
- stall_m is combinational:
  - 1 when state == IDLE & memop & ~oor.
  - 1 when state == ACCESS and neither dmem_ack nor the timeout fires this cycle.
  - 0 otherwise.
- IDLE, no memop: at the edge, data_mw <= exec_out_xm; rd_mw <= rd_xm; wren_mw <= regwrite_xm; exception_mw <= exception_xm. Latency 1 cycle; back-to-back instructions are accepted every cycle.
- IDLE, exception_xm = 1: same pass-through. lw/sw flags are ignored and no memory request is made.
- IDLE, memop & oor: no request. At the edge, data_mw <= EXC_ADDR, rd_mw <= 30, wren_mw <= 1, exception_mw <= 1. Stays in IDLE; no stall.
- IDLE, memop & ~oor: at the edge, go to ACCESS and register the transaction:
  - dmem_req <= 1
  - dmem_we <= isSw_xm
  - dmem_addr <= exec_out_xm[ADDR_W-1:0]
  - dmem_wdata <= rd_out1_xm
  - latch rd_xm and regwrite_xm
  - counter <= 0
  - wren_mw <= 0, so a stale M/W entry is never written twice.
- ACCESS: dmem_req, dmem_addr, dmem_wdata and dmem_we are stable until exit. The counter increments each cycle without ack.
- ACCESS with dmem_ack: at the edge, return to IDLE and clear dmem_req.
  - Load: data_mw <= dmem_rdata, rd_mw <= latched rd, wren_mw <= 1.
  - Store: data_mw <= exec_out_xm, wren_mw <= 0.
  - exception_mw <= 0.
  - stall_m is 0 in the ack cycle, so X/M advances on the same edge.
- ACCESS, counter == TIMEOUT-1 without ack: at the edge, go to IDLE and clear dmem_req. data_mw <= EXC_TIMEOUT, rd_mw <= 30, wren_mw <= 1, exception_mw <= 1. stall_m is 0 that cycle.
- Ack and timeout in the same cycle: ack wins (normal completion).
- dmem_ack while dmem_req = 0: ignored.
- Minimum latency: load/store 2 cycles in M (issue edge plus ack edge); the pipeline stalls 1 cycle with zero-wait memory.
- Store write data is 32 bits and never modified. Memory is word-addressed: no byte lanes, no alignment check.

Test Plan:
- Reset: clrn low mid-ACCESS with dmem_req = 1 -> dmem_req, wren_mw and stall_m drop immediately; after release, state IDLE and all outputs 0.
- ALU pass-through: exec_out_xm = 0x0000_00FF, rd_xm = 3, regwrite_xm = 1 for 3 consecutive cycles -> data_mw = 0xFF, rd_mw = 3, wren_mw = 1 one cycle later each time; stall_m never high.
- Load, ack after 2 wait cycles: isLw_xm, exec_out_xm = 0x10, rd_xm = 5 -> dmem_req = 1, dmem_we = 0, dmem_addr = 0x010; stall_m high 3 cycles; on ack with dmem_rdata = 0xDEADBEEF -> data_mw = 0xDEADBEEF, rd_mw = 5, wren_mw = 1; dmem_req = 0.
- Store, zero-wait: isSw_xm, addr 0x20, rd_out1_xm = 0x1234 -> dmem_we = 1, dmem_wdata = 0x1234; ack next cycle -> wren_mw = 0; stall_m high exactly 1 cycle.
- Timeout: isLw_xm, no ack -> dmem_req high exactly 15 cycles. Then data_mw = 6, rd_mw = 30, wren_mw = 1, exception_mw = 1. Repeat with ack on cycle 15 -> normal load completes, no exception.
- Out-of-range address and upstream exception:
  - isLw_xm, exec_out_xm = 0x0000_1000 -> no dmem_req; data_mw = 7, rd_mw = 30, exception_mw = 1; stall_m stays 0.
  - isSw_xm with exception_xm = 1 -> no request; exception_mw = 1.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: issues req/ack data-memory transactions from X/M and registers results to M/W.
// Latency: 1 cycle for ALU ops and faults, 2+ cycles for lw/sw (issue edge plus ack or timeout edge).
// Backpressure: stall_m freezes X/M and earlier stages while a memory access is still outstanding.
module mem_stage_ctrl #(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned TIMEOUT     = 15,
    parameter logic [31:0] EXC_ADDR    = 32'd7,
    parameter logic [31:0] EXC_TIMEOUT = 32'd6
) (
    input  logic              clock,
    input  logic              clrn,
    input  logic [31:0]       exec_out_xm,
    input  logic [31:0]       rd_out1_xm,
    input  logic [4:0]        rd_xm,
    input  logic              regwrite_xm,
    input  logic              isLw_xm,
    input  logic              isSw_xm,
    input  logic              exception_xm,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_ack,
    input  logic [31:0]       dmem_rdata,
    output logic              stall_m,
    output logic [31:0]       data_mw,
    output logic [4:0]        rd_mw,
    output logic              wren_mw,
    output logic              exception_mw
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [4:0]       EXC_RD   = 5'd30;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [4:0]          rd_lat_q, rd_lat_d;
    logic                dmem_req_q, dmem_req_d;
    logic                dmem_we_q, dmem_we_d;
    logic [ADDR_W-1:0]   dmem_addr_q, dmem_addr_d;
    logic [31:0]         dmem_wdata_q, dmem_wdata_d;
    logic [31:0]         data_mw_q, data_mw_d;
    logic [4:0]          rd_mw_q, rd_mw_d;
    logic                wren_mw_q, wren_mw_d;
    logic                exception_mw_q, exception_mw_d;

    logic memop;
    logic oor;
    logic timeout_hit;

    assign memop       = (isLw_xm | isSw_xm) & ~exception_xm;
    assign oor         = |exec_out_xm[31:ADDR_W];
    assign timeout_hit = (cnt_q == CNT_LAST);

    // Gated by clrn so the pipeline is released the moment reset asserts.
    assign stall_m = clrn & (((state_q == IDLE) & memop & ~oor) |
                             ((state_q == ACCESS) & ~dmem_ack & ~timeout_hit));

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        rd_lat_d       = rd_lat_q;
        dmem_req_d     = dmem_req_q;
        dmem_we_d      = dmem_we_q;
        dmem_addr_d    = dmem_addr_q;
        dmem_wdata_d   = dmem_wdata_q;
        data_mw_d      = data_mw_q;
        rd_mw_d        = rd_mw_q;
        wren_mw_d      = wren_mw_q;
        exception_mw_d = exception_mw_q;
        case (state_q)
            IDLE: begin
                if (memop && !oor) begin
                    state_d      = ACCESS;
                    cnt_d        = '0;
                    rd_lat_d     = rd_xm;
                    dmem_req_d   = 1'b1;
                    dmem_we_d    = isSw_xm;
                    dmem_addr_d  = exec_out_xm[ADDR_W-1:0];
                    dmem_wdata_d = rd_out1_xm;
                    wren_mw_d    = 1'b0;
                end else if (memop) begin
                    data_mw_d      = EXC_ADDR;
                    rd_mw_d        = EXC_RD;
                    wren_mw_d      = 1'b1;
                    exception_mw_d = 1'b1;
                end else begin
                    data_mw_d      = exec_out_xm;
                    rd_mw_d        = rd_xm;
                    wren_mw_d      = regwrite_xm;
                    exception_mw_d = exception_xm;
                end
            end
            ACCESS: begin
                if (dmem_ack) begin
                    state_d        = IDLE;
                    dmem_req_d     = 1'b0;
                    rd_mw_d        = rd_lat_q;
                    exception_mw_d = 1'b0;
                    // X/M is still frozen on the store, so exec_out_xm is its address.
                    if (dmem_we_q) begin
                        data_mw_d = exec_out_xm;
                        wren_mw_d = 1'b0;
                    end else begin
                        data_mw_d = dmem_rdata;
                        wren_mw_d = 1'b1;
                    end
                end else if (timeout_hit) begin
                    state_d        = IDLE;
                    dmem_req_d     = 1'b0;
                    data_mw_d      = EXC_TIMEOUT;
                    rd_mw_d        = EXC_RD;
                    wren_mw_d      = 1'b1;
                    exception_mw_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            rd_lat_q       <= '0;
            dmem_req_q     <= 1'b0;
            dmem_we_q      <= 1'b0;
            dmem_addr_q    <= '0;
            dmem_wdata_q   <= '0;
            data_mw_q      <= '0;
            rd_mw_q        <= '0;
            wren_mw_q      <= 1'b0;
            exception_mw_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            rd_lat_q       <= rd_lat_d;
            dmem_req_q     <= dmem_req_d;
            dmem_we_q      <= dmem_we_d;
            dmem_addr_q    <= dmem_addr_d;
            dmem_wdata_q   <= dmem_wdata_d;
            data_mw_q      <= data_mw_d;
            rd_mw_q        <= rd_mw_d;
            wren_mw_q      <= wren_mw_d;
            exception_mw_q <= exception_mw_d;
        end
    end

    assign dmem_req     = dmem_req_q;
    assign dmem_we      = dmem_we_q;
    assign dmem_addr    = dmem_addr_q;
    assign dmem_wdata   = dmem_wdata_q;
    assign data_mw      = data_mw_q;
    assign rd_mw        = rd_mw_q;
    assign wren_mw      = wren_mw_q;
    assign exception_mw = exception_mw_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed scenarios with literal expectations plus a randomized run
// checked every cycle against a transaction-level model of the memory stage.
module tb_mem_stage_ctrl;

    localparam int ADDR_W  = 12;
    localparam int TIMEOUT = 15;

    logic        clock = 1'b0;
    logic        clrn  = 1'b1;
    logic [31:0] exec_out_xm = '0;
    logic [31:0] rd_out1_xm = '0;
    logic [4:0]  rd_xm = '0;
    logic        regwrite_xm = 1'b0;
    logic        isLw_xm = 1'b0;
    logic        isSw_xm = 1'b0;
    logic        exception_xm = 1'b0;
    logic        dmem_req;
    logic        dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        stall_m;
    logic [31:0] data_mw;
    logic [4:0]  rd_mw;
    logic        wren_mw;
    logic        exception_mw;

    always #5 clock = ~clock;

    mem_stage_ctrl dut (
        .clock(clock), .clrn(clrn),
        .exec_out_xm(exec_out_xm), .rd_out1_xm(rd_out1_xm), .rd_xm(rd_xm),
        .regwrite_xm(regwrite_xm), .isLw_xm(isLw_xm), .isSw_xm(isSw_xm),
        .exception_xm(exception_xm),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .stall_m(stall_m), .data_mw(data_mw), .rd_mw(rd_mw),
        .wren_mw(wren_mw), .exception_mw(exception_mw)
    );

    int n_cmp = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one outstanding access with a count of cycles waited.
    bit          m_busy = 1'b0;
    int          m_wait = 0;
    bit          m_we = 1'b0;
    logic [11:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic [4:0]  m_rd = '0;
    bit          m_last_stall = 1'b0;
    logic [31:0] e_data = '0;
    logic [4:0]  e_rd = '0;
    bit          e_wren = 1'b0;
    bit          e_exc = 1'b0;
    bit          e_valid = 1'b1;
    bit          e_chk_rd = 1'b1;

    function automatic bit f_memop();
        return (isLw_xm || isSw_xm) && !exception_xm;
    endfunction

    function automatic bit f_oor();
        return (exec_out_xm >> ADDR_W) != 0;
    endfunction

    function automatic bit f_stall();
        if (!clrn) return 1'b0;
        if (!m_busy) return f_memop() && !f_oor();
        return !dmem_ack && (m_wait != TIMEOUT - 1);
    endfunction

    always @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            m_busy <= 1'b0; m_wait <= 0; m_we <= 1'b0; m_addr <= '0; m_wdata <= '0; m_rd <= '0;
            m_last_stall <= 1'b0;
            e_data <= '0; e_rd <= '0; e_wren <= 1'b0; e_exc <= 1'b0; e_valid <= 1'b1; e_chk_rd <= 1'b1;
        end else begin
            m_last_stall <= f_stall();
            if (!m_busy) begin
                if (f_memop() && !f_oor()) begin
                    m_busy <= 1'b1; m_wait <= 0; m_we <= isSw_xm;
                    m_addr <= exec_out_xm[11:0]; m_wdata <= rd_out1_xm; m_rd <= rd_xm;
                    e_wren <= 1'b0; e_valid <= 1'b0;
                end else if (f_memop()) begin
                    e_data <= 32'd7; e_rd <= 5'd30; e_wren <= 1'b1; e_exc <= 1'b1;
                    e_valid <= 1'b1; e_chk_rd <= 1'b1;
                end else begin
                    e_data <= exec_out_xm; e_rd <= rd_xm; e_wren <= regwrite_xm; e_exc <= exception_xm;
                    e_valid <= 1'b1; e_chk_rd <= 1'b1;
                end
            end else if (dmem_ack) begin
                m_busy <= 1'b0; e_exc <= 1'b0; e_valid <= 1'b1;
                if (m_we) begin
                    e_data <= exec_out_xm; e_wren <= 1'b0; e_chk_rd <= 1'b0;
                end else begin
                    e_data <= dmem_rdata; e_rd <= m_rd; e_wren <= 1'b1; e_chk_rd <= 1'b1;
                end
            end else if (m_wait == TIMEOUT - 1) begin
                m_busy <= 1'b0;
                e_data <= 32'd6; e_rd <= 5'd30; e_wren <= 1'b1; e_exc <= 1'b1;
                e_valid <= 1'b1; e_chk_rd <= 1'b1;
            end else begin
                m_wait <= m_wait + 1;
            end
        end
    end

    always @(negedge clock) begin
        if (cmp_en) begin
            chk("stall_m", {31'b0, stall_m}, {31'b0, f_stall()});
            chk("dmem_req", {31'b0, dmem_req}, {31'b0, m_busy});
            if (m_busy) begin
                chk("dmem_we", {31'b0, dmem_we}, {31'b0, m_we});
                chk("dmem_addr", {20'b0, dmem_addr}, {20'b0, m_addr});
                chk("dmem_wdata", dmem_wdata, m_wdata);
            end
            chk("wren_mw", {31'b0, wren_mw}, {31'b0, e_wren});
            if (e_valid) begin
                chk("data_mw", data_mw, e_data);
                chk("exception_mw", {31'b0, exception_mw}, {31'b0, e_exc});
                if (e_chk_rd) chk("rd_mw", {27'b0, rd_mw}, {27'b0, e_rd});
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_idle();
        exec_out_xm = '0; rd_out1_xm = '0; rd_xm = '0; regwrite_xm = 1'b0;
        isLw_xm = 1'b0; isSw_xm = 1'b0; exception_xm = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
    endtask

    task automatic set_instr(input bit lw, input bit sw, input bit exc, input logic [31:0] ex,
                             input logic [31:0] sd, input logic [4:0] rd, input bit rw);
        isLw_xm = lw; isSw_xm = sw; exception_xm = exc; exec_out_xm = ex;
        rd_out1_xm = sd; rd_xm = rd; regwrite_xm = rw;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"}, {31'b0, dmem_req}, 32'd0);
        chk({tag, "_we"}, {31'b0, dmem_we}, 32'd0);
        chk({tag, "_addr"}, {20'b0, dmem_addr}, 32'd0);
        chk({tag, "_wdata"}, dmem_wdata, 32'd0);
        chk({tag, "_data"}, data_mw, 32'd0);
        chk({tag, "_rd"}, {27'b0, rd_mw}, 32'd0);
        chk({tag, "_wren"}, {31'b0, wren_mw}, 32'd0);
        chk({tag, "_exc"}, {31'b0, exception_mw}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int stall_cnt;
        int n;
        set_idle();
        #1 clrn = 1'b0;
        #1 cmp_en = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk_all_zero("reset");
        chk("reset_stall", {31'b0, stall_m}, 32'd0);
        clrn = 1'b1;

        // ALU pass-through, three back-to-back instructions
        set_instr(0, 0, 0, 32'h0000_00FF, 32'h0, 5'd3, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("alu_stall", {31'b0, stall_m}, 32'd0);
            tick();
            chk("alu_data", data_mw, 32'hFF);
            chk("alu_rd", {27'b0, rd_mw}, 32'd3);
            chk("alu_wren", {31'b0, wren_mw}, 32'd1);
        end

        // Load with two wait cycles
        set_instr(1, 0, 0, 32'h10, 32'h0, 5'd5, 1);
        stall_cnt = 0;
        @(negedge clock); if (stall_m) stall_cnt++;
        tick();
        chk("ld_req", {31'b0, dmem_req}, 32'd1);
        chk("ld_we", {31'b0, dmem_we}, 32'd0);
        chk("ld_addr", {20'b0, dmem_addr}, 32'h010);
        repeat (2) begin
            @(negedge clock); if (stall_m) stall_cnt++;
            tick();
        end
        dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
        @(negedge clock); if (stall_m) stall_cnt++;
        tick();
        dmem_ack = 1'b0;
        chk("ld_stall_cycles", stall_cnt, 32'd3);
        chk("ld_data", data_mw, 32'hDEADBEEF);
        chk("ld_rd", {27'b0, rd_mw}, 32'd5);
        chk("ld_wren", {31'b0, wren_mw}, 32'd1);
        chk("ld_req_done", {31'b0, dmem_req}, 32'd0);
        set_idle();

        // Zero-wait store
        set_instr(0, 1, 0, 32'h20, 32'h1234, 5'd0, 0);
        stall_cnt = 0;
        @(negedge clock); if (stall_m) stall_cnt++;
        tick();
        chk("st_we", {31'b0, dmem_we}, 32'd1);
        chk("st_wdata", dmem_wdata, 32'h1234);
        dmem_ack = 1'b1;
        @(negedge clock); if (stall_m) stall_cnt++;
        tick();
        dmem_ack = 1'b0;
        chk("st_stall_cycles", stall_cnt, 32'd1);
        chk("st_wren", {31'b0, wren_mw}, 32'd0);
        chk("st_req_done", {31'b0, dmem_req}, 32'd0);
        set_idle();

        // Timeout: no ack at all
        set_instr(1, 0, 0, 32'h30, 32'h0, 5'd7, 1);
        tick();
        n = 0;
        while (dmem_req === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        chk("to_req_cycles", n, 32'd15);
        chk("to_data", data_mw, 32'd6);
        chk("to_rd", {27'b0, rd_mw}, 32'd30);
        chk("to_wren", {31'b0, wren_mw}, 32'd1);
        chk("to_exc", {31'b0, exception_mw}, 32'd1);
        set_idle();

        // Ack arriving in the last cycle before timeout wins
        set_instr(1, 0, 0, 32'h31, 32'h0, 5'd8, 1);
        tick();
        for (int k = 1; k < 15; k++) tick();
        chk("late_req", {31'b0, dmem_req}, 32'd1);
        dmem_ack = 1'b1; dmem_rdata = 32'hCAFEF00D;
        tick();
        dmem_ack = 1'b0;
        chk("late_data", data_mw, 32'hCAFEF00D);
        chk("late_exc", {31'b0, exception_mw}, 32'd0);
        chk("late_rd", {27'b0, rd_mw}, 32'd8);
        set_idle();

        // Out-of-range address
        set_instr(1, 0, 0, 32'h0000_1000, 32'h0, 5'd9, 1);
        @(negedge clock);
        chk("oor_stall", {31'b0, stall_m}, 32'd0);
        tick();
        chk("oor_req", {31'b0, dmem_req}, 32'd0);
        chk("oor_data", data_mw, 32'd7);
        chk("oor_rd", {27'b0, rd_mw}, 32'd30);
        chk("oor_exc", {31'b0, exception_mw}, 32'd1);
        set_idle();

        // Upstream exception on a store
        set_instr(0, 1, 1, 32'h44, 32'h55, 5'd4, 0);
        @(negedge clock);
        chk("uexc_stall", {31'b0, stall_m}, 32'd0);
        tick();
        chk("uexc_req", {31'b0, dmem_req}, 32'd0);
        chk("uexc_exc", {31'b0, exception_mw}, 32'd1);
        set_idle();

        // Reset in the middle of an access
        set_instr(1, 0, 0, 32'h50, 32'h0, 5'd10, 1);
        tick();
        chk("rst_pre_req", {31'b0, dmem_req}, 32'd1);
        #2 clrn = 1'b0;
        #1;
        chk("rst_req", {31'b0, dmem_req}, 32'd0);
        chk("rst_wren", {31'b0, wren_mw}, 32'd0);
        chk("rst_stall", {31'b0, stall_m}, 32'd0);
        set_idle();
        tick();
        tick();
        clrn = 1'b1;
        chk_all_zero("rst_rel");

        // Randomized traffic; X/M holds while the previous edge stalled
        for (int c = 0; c < 3000; c++) begin
            if (!m_last_stall) begin
                int kind;
                kind = $urandom_range(0, 9);
                set_instr(0, 0, 0, $urandom & 32'hFFF, $urandom, 5'($urandom), 1'($urandom));
                if (kind >= 4 && kind <= 5) isLw_xm = 1'b1;
                else if (kind >= 6 && kind <= 7) isSw_xm = 1'b1;
                else if (kind == 8) begin
                    isLw_xm = 1'($urandom); isSw_xm = ~isLw_xm;
                    exec_out_xm = $urandom | 32'h1000;
                end else if (kind == 9) begin
                    isLw_xm = 1'($urandom); isSw_xm = ~isLw_xm; exception_xm = 1'b1;
                end
            end
            dmem_ack   = m_busy ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 7) == 0);
            dmem_rdata = $urandom;
            if ($urandom_range(0, 399) == 0) begin
                #2 clrn = 1'b0;
                tick();
                clrn = 1'b1;
            end else begin
                tick();
            end
        end

        set_idle();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
